// File: rtl/centroid_pkg.sv
// centroid_pkg: shared state/quadrant encodings and width helper for centroid_tracker.
package centroid_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, EMIT} centroid_state_t;
  typedef enum logic [1:0] {TOP = 2'b00, BOTTOM = 2'b01, RIGHT = 2'b10, LEFT = 2'b11} rotate_t;
  function automatic int cnt_width(input int max_pixels);
    return $clog2(max_pixels + 1);
  endfunction
endpackage

// File: rtl/centroid_tracker_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle; done holds until the next start.
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int Q_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);
  localparam int LW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] dq, rem, dvs, cur_dq, cur_rem, cur_dvs, nrem;
  logic [WIDTH:0] trial;
  logic [LW-1:0] left;
  logic take;
  // the first bit is resolved on the start edge so WIDTH edges yield the full quotient
  always_comb begin
    cur_dq = start ? dividend : dq;
    cur_rem = start ? '0 : rem;
    cur_dvs = start ? divisor : dvs;
    trial = {cur_rem, cur_dq[WIDTH-1]};
    take = trial >= {1'b0, cur_dvs};
    nrem = take ? trial[WIDTH-1:0] - cur_dvs : trial[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dq <= '0;
      rem <= '0;
      dvs <= '0;
      left <= '0;
      done <= 1'b0;
    end else if (start || left != '0) begin
      dq <= {cur_dq[WIDTH-2:0], take};
      rem <= nrem;
      dvs <= cur_dvs;
      left <= start ? LW'(WIDTH - 1) : left - LW'(1);
      done <= start ? WIDTH == 1 : left == LW'(1);
    end
  assign quotient = dq[Q_W-1:0];
endmodule

// File: rtl/centroid_tracker.sv
// centroid_tracker: per-channel centre-of-mass with double-buffered accumulators and ready/valid output.
// Define CENTROID_BBOX_EN to add per-channel min/max bounding-box tracking and outputs.
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int X_W = 11,
  parameter int Y_W = 10,
  parameter int MAX_PIXELS = 1024 * 720,
  parameter int MIN_COUNT = 16,
  parameter int FRAME_W = 1280,
  parameter int FRAME_H = 720,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [CHANNELS-1:0] mask_in,
  input  logic                valid_in,
  input  logic                tabulate_in,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [CH_W-1:0]     chan_out,
  output logic                empty_out,
  output logic [1:0]          rotate_out,
  output logic                valid_out,
`ifdef CENTROID_BBOX_EN
  output logic [X_W-1:0]      xmin_out,
  output logic [X_W-1:0]      xmax_out,
  output logic [Y_W-1:0]      ymin_out,
  output logic [Y_W-1:0]      ymax_out,
`endif
  input  logic                ready_in,
  output logic                busy_out,
  output logic                overrun_out
);
  localparam int CNT_W = cnt_width(MAX_PIXELS);
  localparam int XS_W = X_W + CNT_W;
  localparam int YS_W = Y_W + CNT_W;
  localparam int P_W = X_W + Y_W + 32;
  centroid_state_t state;
  logic [XS_W-1:0] xs [CHANNELS], nxs [CHANNELS], sxs [CHANNELS];
  logic [YS_W-1:0] ys [CHANNELS], nys [CHANNELS], sys [CHANNELS];
  logic [CNT_W-1:0] cnt [CHANNELS], ncnt [CHANNELS], scnt [CHANNELS];
  logic [CHANNELS-1:0] hit;
  logic [CH_W-1:0] ch;
  logic tab_ok, start, done_x, done_y, is_empty;
  logic [X_W-1:0] qx;
  logic [Y_W-1:0] qy;
  logic [P_W-1:0] a, b;
  rotate_t rot;
  assign tab_ok = tabulate_in && !busy_out;
  assign start = state == LOAD && scnt[ch] >= CNT_W'(MIN_COUNT);
  // next-live values include the current pixel, so a same-cycle pixel lands in the snapshot
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = valid_in && mask_in[c] && cnt[c] != CNT_W'(MAX_PIXELS);
      nxs[c] = xs[c] + (hit[c] ? XS_W'(x_in) : '0);
      nys[c] = ys[c] + (hit[c] ? YS_W'(y_in) : '0);
      ncnt[c] = cnt[c] + (hit[c] ? CNT_W'(1) : '0);
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      for (int c = 0; c < CHANNELS; c++) begin
        xs[c] <= '0;
        ys[c] <= '0;
        cnt[c] <= '0;
        sxs[c] <= '0;
        sys[c] <= '0;
        scnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        xs[c] <= tabulate_in ? '0 : nxs[c];
        ys[c] <= tabulate_in ? '0 : nys[c];
        cnt[c] <= tabulate_in ? '0 : ncnt[c];
        sxs[c] <= tab_ok ? nxs[c] : sxs[c];
        sys[c] <= tab_ok ? nys[c] : sys[c];
        scnt[c] <= tab_ok ? ncnt[c] : scnt[c];
      end
    end
  seq_divider #(.WIDTH(XS_W), .Q_W(X_W)) u_div_x (
    .clk(clk_in), .rst_n(rst_n_in), .start(start), .dividend(sxs[ch]),
    .divisor(XS_W'(scnt[ch])), .done(done_x), .quotient(qx)
  );
  seq_divider #(.WIDTH(YS_W), .Q_W(Y_W)) u_div_y (
    .clk(clk_in), .rst_n(rst_n_in), .start(start), .dividend(sys[ch]),
    .divisor(YS_W'(scnt[ch])), .done(done_y), .quotient(qy)
  );
  always_comb begin
    a = P_W'(FRAME_H) * P_W'(qx);
    b = P_W'(FRAME_W) * P_W'(qy);
    rot = (a + b <= P_W'(FRAME_W * FRAME_H)) ? (a > b ? TOP : LEFT) : (a > b ? RIGHT : BOTTOM);
  end
  // outputs are loaded on the first EMIT cycle, then frozen until the handshake
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      ch <= '0;
      is_empty <= 1'b0;
      busy_out <= 1'b0;
      overrun_out <= 1'b0;
      valid_out <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      chan_out <= '0;
      empty_out <= 1'b0;
      rotate_out <= '0;
    end else begin
      overrun_out <= tabulate_in && busy_out;
      case (state)
        IDLE: if (tabulate_in) begin
          state <= LOAD;
          ch <= '0;
          busy_out <= 1'b1;
        end
        LOAD: begin
          is_empty <= !start;
          state <= start ? DIVIDE : EMIT;
        end
        DIVIDE: if (done_x && done_y) state <= EMIT;
        EMIT: if (!valid_out) begin
          valid_out <= 1'b1;
          x_out <= is_empty ? '0 : qx;
          y_out <= is_empty ? '0 : qy;
          chan_out <= ch;
          empty_out <= is_empty;
          rotate_out <= is_empty ? TOP : rot;
        end else if (ready_in) begin
          valid_out <= 1'b0;
          state <= ch == CH_W'(CHANNELS - 1) ? IDLE : LOAD;
          busy_out <= ch != CH_W'(CHANNELS - 1);
          ch <= ch + CH_W'(1);
        end
      endcase
    end
`ifdef CENTROID_BBOX_EN
  logic [X_W-1:0] xmn [CHANNELS], xmx [CHANNELS], nxmn [CHANNELS], nxmx [CHANNELS], sxmn [CHANNELS], sxmx [CHANNELS];
  logic [Y_W-1:0] ymn [CHANNELS], ymx [CHANNELS], nymn [CHANNELS], nymx [CHANNELS], symn [CHANNELS], symx [CHANNELS];
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      nxmn[c] = hit[c] && x_in < xmn[c] ? x_in : xmn[c];
      nxmx[c] = hit[c] && x_in > xmx[c] ? x_in : xmx[c];
      nymn[c] = hit[c] && y_in < ymn[c] ? y_in : ymn[c];
      nymx[c] = hit[c] && y_in > ymx[c] ? y_in : ymx[c];
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      for (int c = 0; c < CHANNELS; c++) begin
        xmn[c] <= '1;
        xmx[c] <= '0;
        ymn[c] <= '1;
        ymx[c] <= '0;
        sxmn[c] <= '0;
        sxmx[c] <= '0;
        symn[c] <= '0;
        symx[c] <= '0;
      end
      xmin_out <= '0;
      xmax_out <= '0;
      ymin_out <= '0;
      ymax_out <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        xmn[c] <= tabulate_in ? '1 : nxmn[c];
        xmx[c] <= tabulate_in ? '0 : nxmx[c];
        ymn[c] <= tabulate_in ? '1 : nymn[c];
        ymx[c] <= tabulate_in ? '0 : nymx[c];
        sxmn[c] <= tab_ok ? nxmn[c] : sxmn[c];
        sxmx[c] <= tab_ok ? nxmx[c] : sxmx[c];
        symn[c] <= tab_ok ? nymn[c] : symn[c];
        symx[c] <= tab_ok ? nymx[c] : symx[c];
      end
      if (state == EMIT && !valid_out) begin
        xmin_out <= is_empty ? '0 : sxmn[ch];
        xmax_out <= is_empty ? '0 : sxmx[ch];
        ymin_out <= is_empty ? '0 : symn[ch];
        ymax_out <= is_empty ? '0 : symx[ch];
      end
    end
`endif
endmodule

// File: tb/tb_centroid_tracker.sv
// tb_centroid_tracker: scoreboard bench; a behavioural model predicts each frame's per-channel results.
module tb_centroid_tracker;
  localparam int CH = 4;
  localparam int MAXP = 1024 * 720;
  logic clk_in = 0, rst_n_in = 0;
  logic [10:0] x_in = '0;
  logic [9:0] y_in = '0;
  logic [3:0] mask_in = '0;
  logic valid_in = 0, tabulate_in = 0, ready_in = 1;
  logic [10:0] x_out;
  logic [9:0] y_out;
  logic [1:0] chan_out, rotate_out;
  logic empty_out, valid_out, busy_out, overrun_out;
`ifdef CENTROID_BBOX_EN
  logic [10:0] xmin_out, xmax_out;
  logic [9:0] ymin_out, ymax_out;
`endif
  centroid_tracker dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .x_in(x_in), .y_in(y_in), .mask_in(mask_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in), .x_out(x_out), .y_out(y_out),
    .chan_out(chan_out), .empty_out(empty_out), .rotate_out(rotate_out), .valid_out(valid_out),
`ifdef CENTROID_BBOX_EN
    .xmin_out(xmin_out), .xmax_out(xmax_out), .ymin_out(ymin_out), .ymax_out(ymax_out),
`endif
    .ready_in(ready_in), .busy_out(busy_out), .overrun_out(overrun_out)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {int ch; int x; int y; int empty; int rot;} exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0, ov_seen = 0, ov_exp = 0;
  longint sx[CH], sy[CH];
  int sc[CH];
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic exp_t model(int c);
    exp_t e;
    longint a, b;
    e.ch = c;
    e.empty = sc[c] < 16;
    e.x = e.empty ? 0 : int'(sx[c] / sc[c]);
    e.y = e.empty ? 0 : int'(sy[c] / sc[c]);
    a = 720 * longint'(e.x);
    b = 1280 * longint'(e.y);
    e.rot = e.empty ? 0 : (a + b <= 921600) ? (a > b ? 0 : 3) : (a > b ? 2 : 1);
    return e;
  endfunction
  task automatic clear_model();
    for (int c = 0; c < CH; c++) begin
      sx[c] = 0;
      sy[c] = 0;
      sc[c] = 0;
    end
  endtask
  task automatic acc(int x, int y, logic [3:0] m);
    for (int c = 0; c < CH; c++)
      if (m[c] && sc[c] < MAXP) begin
        sx[c] += x;
        sy[c] += y;
        sc[c]++;
      end
  endtask
  task automatic px(int x, int y, logic [3:0] m);
    @(posedge clk_in); #1;
    x_in = 11'(x); y_in = 10'(y); mask_in = m; valid_in = 1; tabulate_in = 0;
    acc(x, y, m);
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      valid_in = 0; tabulate_in = 0;
    end
  endtask
  task automatic tab(bit ov, bit with_px = 0, int x = 0, int y = 0, logic [3:0] m = 0);
    @(posedge clk_in); #1;
    tabulate_in = 1; valid_in = with_px; x_in = 11'(x); y_in = 10'(y); mask_in = m;
    if (with_px) acc(x, y, m);
    if (ov) ov_exp++;
    else for (int c = 0; c < CH; c++) sb.push_back(model(c));
    clear_model();
    @(posedge clk_in); #1;
    tabulate_in = 0; valid_in = 0;
    check(ov ? "overrun_pulse" : "no_overrun", overrun_out, ov);
    if (!ov) check("busy_rise", busy_out, 1);
  endtask
  task automatic drain();
    int i = 0;
    while (i < 20000 && (sb.size() != 0 || busy_out)) begin
      @(negedge clk_in);
      i++;
    end
    check("drain_done", i < 20000, 1);
  endtask
  task automatic check_reset(string t);
    check({t, "_valid"}, valid_out, 0);
    check({t, "_busy"}, busy_out, 0);
    check({t, "_x"}, x_out, 0);
    check({t, "_y"}, y_out, 0);
    check({t, "_chan"}, chan_out, 0);
    check({t, "_empty"}, empty_out, 0);
    check({t, "_rotate"}, rotate_out, 0);
    check({t, "_overrun"}, overrun_out, 0);
  endtask
  logic hold = 0;
  logic [25:0] hsnap;
  always @(negedge clk_in) begin
    exp_t e;
    if (hold) begin
      check("hold_valid", valid_out, 1);
      check("hold_data", {x_out, y_out, chan_out, empty_out, rotate_out}, hsnap);
    end
    hold = valid_out && !ready_in;
    hsnap = {x_out, y_out, chan_out, empty_out, rotate_out};
    if (valid_out && ready_in) begin
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("chan", chan_out, e.ch);
        check("x", x_out, e.x);
        check("y", y_out, e.y);
        check("empty", empty_out, e.empty);
        check("rotate", rotate_out, e.rot);
      end
    end
    if (overrun_out) ov_seen++;
  end
  initial begin
    int w;
    clear_model();
    repeat (3) @(posedge clk_in);
    #1 check_reset("rst");
    rst_n_in = 1;
    repeat (16) px(100, 50, 4'b0001);
    tab(0);
    drain();
    for (int i = 0; i < 32; i++) px(i % 2 ? 200 : 0, i % 2 ? 100 : 0, 4'b0011);
    tab(0);
    drain();
    repeat (16) px(100, 50, 4'b0001);
    ready_in = 0;
    tab(0);
    w = 0;
    while (!valid_out && w < 1000) begin
      @(negedge clk_in);
      w++;
    end
    check("bp_valid_seen", valid_out, 1);
    repeat (20) @(negedge clk_in);
    @(posedge clk_in); #1 ready_in = 1;
    drain();
    repeat (16) px(100, 50, 4'b0001);
    tab(0);
    idle(5);
    repeat (4) px(300, 300, 4'b1111);
    tab(1);
    drain();
    repeat (16) px(1200, 360, 4'b0001);
    tab(0);
    drain();
    check("overrun_count", ov_seen, ov_exp);
    repeat (16) px(1200, 360, 4'b0001);
    repeat (16) px(640, 700, 4'b0010);
    repeat (16) px(50, 360, 4'b0100);
    repeat (15) px(100, 50, 4'b1000);
    tab(0, 1, 100, 50, 4'b1000);
    drain();
    repeat (16) px(500, 500, 4'b0001);
    tab(0);
    idle(8);
    rst_n_in = 0;
    sb.delete();
    clear_model();
    #1 check_reset("mid_rst");
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1;
    repeat (16) px(640, 700, 4'b0100);
    tab(0);
    drain();
    check("sb_left", sb.size(), 0);
    check("overrun_total", ov_seen, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
